aux_reply_handler: RTL and testbench

Collects the per-transaction output of the AUX reply decoder (ACK byte strobe followed by data-byte strobes), classifies the reply, buffers the data bytes and reports one completion status per request to the AUX request controller. It owns the reply-timeout and DEFER-retry policy. It sits directly downstream of the reply decoder and upstream of the link/stream policy logic that reads back reply data.

---
 rtl/aux_reply_handler_if.sv | 41 ++++
 rtl/aux_reply_handler.sv | 200 ++++++++++++++++++++
 tb/tb_aux_reply_handler.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aux_reply_handler_if.sv
// AUX reply handler bus: request kick-off, decoder strobes,
// reply buffer read port and completion reporting.
interface aux_reply_handler_if;
  logic       req_start;
  logic [4:0] req_len;
  logic       req_i2c_native;
  logic [1:0] reply_ack;
  logic       reply_ack_vld;
  logic [7:0] reply_data;
  logic       reply_data_vld;
  logic       reply_dec_i2c_native;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_empty;
  logic [4:0] rx_count;
  logic       done;
  logic [2:0] status;
  logic       retry_req;
  logic [2:0] defer_cnt;
  logic       busy;

  modport master (
    output req_start, req_len, req_i2c_native,
    output reply_ack, reply_ack_vld,
    output reply_data, reply_data_vld,
    output reply_dec_i2c_native, rd_en,
    input  rd_data, rd_empty, rx_count,
    input  done, status, retry_req,
    input  defer_cnt, busy
  );

  modport slave (
    input  req_start, req_len, req_i2c_native,
    input  reply_ack, reply_ack_vld,
    input  reply_data, reply_data_vld,
    input  reply_dec_i2c_native, rd_en,
    output rd_data, rd_empty, rx_count,
    output done, status, retry_req,
    output defer_cnt, busy
  );
endinterface

// File: rtl/aux_reply_handler.sv
// AUX reply collector: classifies each reply, buffers its data
// bytes and owns the reply-timeout and DEFER-retry policy.
module aux_reply_handler #(
  parameter int BUF_DEPTH      = 16,
  parameter int TIMEOUT_CYCLES = 400,
  parameter int MAX_DEFER      = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  aux_reply_handler_if.slave bus
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] C_ACK   = 2'b00;
  localparam logic [1:0] C_NACK  = 2'b01;
  localparam logic [1:0] C_DEFER = 2'b10;
  localparam logic [1:0] C_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_RX_DATA,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    len_q, len_d;
  logic          mode_q, mode_d;
  logic          rmode_q, rmode_d;
  logic [1:0]    code_q, code_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          retry_q, retry_d;
  logic          busy_q, busy_d;
  logic [2:0]    status_q, status_d;
  logic [2:0]    defer_q, defer_d;
  logic [7:0]    mem_q [BUF_DEPTH];
  logic          wr_en;
  logic          pop;
  logic          empty;

  assign empty = (wptr_q == rptr_q);
  assign pop   = bus.rd_en && !empty;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    len_d    = len_q;
    mode_d   = mode_q;
    rmode_d  = rmode_q;
    code_d   = code_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    defer_d  = defer_q;
    done_d   = 1'b0;
    retry_d  = 1'b0;
    wr_en    = 1'b0;
    rptr_d   = rptr_q + (AW+1)'(pop);
    unique case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_WAIT_ACK: begin
        if (bus.reply_ack_vld) begin
          code_d  = bus.reply_ack;
          rmode_d = bus.reply_dec_i2c_native;
          state_d = S_RX_DATA;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          status_d = 3'd3;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RX_DATA: begin
        if (bus.reply_data_vld) begin
          if (code_q == C_ACK) begin
            if (cnt_q < len_q) begin
              wr_en = 1'b1;
              cnt_d = cnt_q + 5'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end else if (!bus.reply_ack_vld) begin
          // first idle cycle closes the reply
          state_d = S_DONE;
          done_d  = 1'b1;
          if (code_q == C_RSVD) begin
            status_d = 3'd6;
          end else if (rmode_q != mode_q) begin
            status_d = 3'd7;
          end else if (code_q == C_NACK) begin
            status_d = 3'd1;
          end else if (code_q == C_DEFER) begin
            if (defer_q < 3'(MAX_DEFER)) begin
              defer_d = defer_q + 3'd1;
              retry_d = 1'b1;
              done_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              status_d = 3'd2;
            end
          end else if (ovf_q) begin
            status_d = 3'd5;
          end else if (cnt_q < len_q) begin
            status_d = 3'd4;
          end else begin
            status_d = 3'd0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        defer_d = 3'd0;
      end
      default: state_d = S_IDLE;
    endcase
    wptr_d = wptr_q + (AW+1)'(wr_en);
    // a new request aborts whatever is in flight
    if (bus.req_start) begin
      state_d  = S_WAIT_ACK;
      timer_d  = '0;
      len_d    = bus.req_len;
      mode_d   = bus.req_i2c_native;
      ovf_d    = 1'b0;
      cnt_d    = 5'd0;
      wptr_d   = '0;
      rptr_d   = '0;
      wr_en    = 1'b0;
      done_d   = 1'b0;
      retry_d  = 1'b0;
      status_d = status_q;
      defer_d  = defer_q;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      len_q    <= 5'd0;
      mode_q   <= 1'b0;
      rmode_q  <= 1'b0;
      code_q   <= 2'b00;
      ovf_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= 5'd0;
      done_q   <= 1'b0;
      retry_q  <= 1'b0;
      busy_q   <= 1'b0;
      status_q <= 3'd0;
      defer_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      rmode_q  <= rmode_d;
      code_q   <= code_d;
      ovf_q    <= ovf_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      retry_q  <= retry_d;
      busy_q   <= busy_d;
      status_q <= status_d;
      defer_q  <= defer_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wr_en) begin
      mem_q[wptr_q[AW-1:0]] <= bus.reply_data;
    end
  end

  assign bus.rd_data   = mem_q[rptr_q[AW-1:0]];
  assign bus.rd_empty  = empty;
  assign bus.rx_count  = cnt_q;
  assign bus.done      = done_q;
  assign bus.status    = status_q;
  assign bus.retry_req = retry_q;
  assign bus.defer_cnt = defer_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aux_reply_handler.sv
// Randomised and directed bench for aux_reply_handler against a
// transaction-level reply model.
module tb_aux_reply_handler;

  localparam int TMO  = 400;
  localparam int MAXD = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  aux_reply_handler_if bus();

  aux_reply_handler #(
    .BUF_DEPTH     (16),
    .TIMEOUT_CYCLES(TMO),
    .MAX_DEFER     (MAXD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reply model: phase 0 idle, 1 awaiting ack, 2 collecting, 3 completing
  int         m_phase;
  logic [7:0] m_buf[$];
  int         m_len, m_cnt, m_code;
  bit         m_mode, m_rmode, m_ovf;
  longint     cyc = 0;
  longint     m_t0;
  bit         e_done, e_retry, e_busy;
  int         e_status, e_defer;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_buf.delete();
    m_len = 0; m_cnt = 0; m_code = 0;
    m_mode = 0; m_rmode = 0; m_ovf = 0;
    e_done = 0; e_retry = 0; e_busy = 0;
    e_status = 0; e_defer = 0;
  endtask

  task automatic finish_with(int s);
    e_done = 1; e_status = s; m_phase = 3;
  endtask

  task automatic resolve();
    if (m_code == 3) finish_with(6);
    else if (m_rmode != m_mode) finish_with(7);
    else if (m_code == 1) finish_with(1);
    else if (m_code == 2) begin
      if (e_defer < MAXD) begin
        e_defer++; e_retry = 1; m_phase = 0;
      end else finish_with(2);
    end
    else if (m_ovf) finish_with(5);
    else if (m_cnt < m_len) finish_with(4);
    else finish_with(0);
  endtask

  task automatic model_update();
    cyc++;
    e_done = 0; e_retry = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (bus.req_start) begin
      m_buf.delete();
      m_cnt = 0; m_ovf = 0;
      m_len = int'(bus.req_len);
      m_mode = bus.req_i2c_native;
      m_t0 = cyc; m_phase = 1; e_busy = 1;
      return;
    end
    if (bus.rd_en && m_buf.size() > 0) void'(m_buf.pop_front());
    case (m_phase)
      1: begin
        if (bus.reply_ack_vld) begin
          m_code = int'(bus.reply_ack);
          m_rmode = bus.reply_dec_i2c_native;
          m_phase = 2;
        end else if (cyc - m_t0 == TMO) finish_with(3);
      end
      2: begin
        if (bus.reply_data_vld) begin
          if (m_code == 0) begin
            if (m_cnt < m_len) begin
              m_buf.push_back(bus.reply_data);
              m_cnt++;
            end else m_ovf = 1;
          end
        end else if (!bus.reply_ack_vld) resolve();
      end
      3: begin
        m_phase = 0; e_defer = 0;
      end
      default: ;
    endcase
    e_busy = (m_phase != 0);
  endtask

  always @(negedge clk) begin
    check("done", bus.done, e_done);
    check("retry_req", bus.retry_req, e_retry);
    check("status", bus.status, e_status);
    check("defer_cnt", bus.defer_cnt, e_defer);
    check("busy", bus.busy, e_busy);
    check("rx_count", bus.rx_count, m_cnt);
    check("rd_empty", bus.rd_empty, m_buf.size() == 0);
    if (m_buf.size() != 0) check("rd_data", bus.rd_data, m_buf[0]);
  end

  task automatic idle_inputs();
    bus.req_start = 0;
    bus.reply_ack_vld = 0;
    bus.reply_data_vld = 0;
    bus.rd_en = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    idle_inputs();
  endtask

  task automatic req(int len, bit i2c);
    bus.req_start = 1;
    bus.req_len = 5'(len);
    bus.req_i2c_native = i2c;
    step();
  endtask

  task automatic send_reply(int code, bit mode, input logic [7:0] q[$],
                            bit fin, bit rnd);
    bus.reply_ack = 2'(code);
    bus.reply_ack_vld = 1;
    bus.reply_dec_i2c_native = mode;
    if (rnd) bus.rd_en = 1'($urandom_range(0, 1));
    step();
    foreach (q[i]) begin
      bus.reply_data_vld = 1;
      bus.reply_data = q[i];
      if (rnd) begin
        bus.rd_en = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 4) == 0) begin
          bus.reply_ack_vld = 1;
          bus.reply_ack = 2'($urandom_range(0, 3));
        end
      end
      step();
    end
    if (fin) begin
      if (rnd) bus.rd_en = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      bus.rd_en = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    check("drain_bound", n < budget, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp4[4];
    int n;
    bit skip_gap;
    idle_inputs();
    bus.req_len = 0; bus.req_i2c_native = 0;
    bus.reply_ack = 0; bus.reply_data = 0;
    bus.reply_dec_i2c_native = 0;
    model_reset();
    step(); step();
    check("rst_rd_data", bus.rd_data, 8'h00);
    check("rst_rd_empty", bus.rd_empty, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_status", bus.status, 0);
    rst_n = 1;

    // native read of four bytes
    req(4, 0);
    step(); step();
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_reply(0, 0, q, 1, 0);
    check("rd4_done", bus.done, 1);
    check("rd4_status", bus.status, 0);
    check("rd4_cnt", bus.rx_count, 4);
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      check("rd4_pop", bus.rd_data, exp4[i]);
      bus.rd_en = 1;
      step();
    end
    check("rd4_empty", bus.rd_empty, 1);

    // native write, NACK
    q.delete();
    req(0, 0);
    send_reply(1, 0, q, 1, 0);
    check("wr_done", bus.done, 1);
    check("wr_status", bus.status, 1);
    check("wr_empty", bus.rd_empty, 1);
    step();

    // seven DEFERs then ACK
    for (int k = 1; k <= 7; k++) begin
      req(1, 0);
      send_reply(2, 0, q, 1, 0);
      check("defer_retry", bus.retry_req, 1);
      check("defer_cnt_k", bus.defer_cnt, k);
    end
    q = '{8'h5A};
    req(1, 0);
    send_reply(0, 0, q, 1, 0);
    check("defer_ok_done", bus.done, 1);
    check("defer_ok_status", bus.status, 0);
    step();
    check("defer_cleared", bus.defer_cnt, 0);

    // eight DEFERs exhaust the retry budget
    q.delete();
    for (int k = 1; k <= 8; k++) begin
      req(1, 0);
      send_reply(2, 0, q, 1, 0);
    end
    check("defer_x_done", bus.done, 1);
    check("defer_x_status", bus.status, 2);
    step();

    // reply timeout
    req(0, 0);
    n = 0;
    while (!bus.done && n < TMO + 50) begin
      step();
      n++;
    end
    check("tmo_cycles", n, 400);
    check("tmo_status", bus.status, 3);
    step();

    // I2C read overflow and short reply
    q = '{8'hA1, 8'hA2, 8'hA3};
    req(2, 1);
    send_reply(0, 1, q, 1, 0);
    check("ovf_status", bus.status, 5);
    check("ovf_cnt", bus.rx_count, 2);
    step();
    q = '{8'hB1};
    req(2, 1);
    send_reply(0, 1, q, 1, 0);
    check("short_status", bus.status, 4);
    check("short_cnt", bus.rx_count, 1);
    step();

    // mode mismatch
    q = '{8'h01, 8'h02, 8'h03};
    req(3, 1);
    send_reply(0, 0, q, 1, 0);
    check("mm_status", bus.status, 7);
    step();

    // abort mid-reply with a new request
    q = '{8'hC1, 8'hC2};
    req(4, 0);
    send_reply(0, 0, q, 0, 0);
    req(3, 0);
    check("abort_cnt", bus.rx_count, 0);
    check("abort_empty", bus.rd_empty, 1);
    check("abort_nodone", bus.done, 0);
    q = '{8'hD1, 8'hD2, 8'hD3};
    send_reply(0, 0, q, 1, 0);
    check("abort_status", bus.status, 0);
    check("abort_head", bus.rd_data, 8'hD1);
    step();

    // asynchronous reset mid-transaction
    q = '{8'hE1, 8'hE2};
    req(4, 0);
    send_reply(0, 0, q, 0, 0);
    rst_n = 0;
    model_reset();
    #2;
    check("arst_busy", bus.busy, 0);
    check("arst_cnt", bus.rx_count, 0);
    check("arst_rd_data", bus.rd_data, 8'h00);
    step(); step();
    rst_n = 1;
    step();

    // randomised traffic
    skip_gap = 0;
    for (int t = 0; t < 300; t++) begin
      int len, r, code, nb;
      bit i2c, mode, ab;
      if (!skip_gap) begin
        repeat ($urandom_range(0, 2)) begin
          bus.rd_en = 1'($urandom_range(0, 1));
          step();
        end
      end
      skip_gap = 0;
      len = $urandom_range(0, 16);
      i2c = 1'($urandom_range(0, 1));
      req(len, i2c);
      r = $urandom_range(0, 99);
      if (r < 3) begin
        n = 0;
        while (!bus.done && n < TMO + 10) begin
          step();
          n++;
        end
        check("rnd_tmo_bound", n < TMO + 10, 1);
        drain(4);
        continue;
      end
      repeat ($urandom_range(0, 4)) begin
        bus.rd_en = 1'($urandom_range(0, 1));
        step();
      end
      r = $urandom_range(0, 99);
      code = (r < 60) ? 0 : (r < 72) ? 1 : (r < 90) ? 2 : 3;
      mode = ($urandom_range(0, 9) == 0) ? !i2c : i2c;
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 18) : len;
      q.delete();
      for (int i = 0; i < nb; i++) q.push_back(8'($urandom));
      ab = ($urandom_range(0, 14) == 0);
      send_reply(code, mode, q, !ab, 1);
      if (ab) skip_gap = 1;
      else drain(4);
    end
    drain(8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
